// File: rtl/stack_spill_pkg.sv
// Shared constants and state type for the J1a stack spill store.
// Optional high-water mark is enabled with STACK_SPILL_HWM_EN.
package stack_spill_pkg;
   localparam int WIDTH       = 16;
   localparam int SPILL_DEPTH = 256;
   localparam int AW          = $clog2(SPILL_DEPTH);

   localparam logic [WIDTH-1:0] FILL_PATTERN = 16'h55aa;

   typedef enum logic {IDLE, FILL} state_t;
endpackage

// File: rtl/stack_spill_if.sv
// Stack-bottom and RAM-side signal bundle of the spill store.
// hwm exists only when STACK_SPILL_HWM_EN is defined.
interface stack_spill_if;
   import stack_spill_pkg::*;

   logic             bot_push;
   logic [WIDTH-1:0] bot_wd;
   logic             bot_pop;
   logic [WIDTH-1:0] bot_rd;
   logic             ready;
   logic [AW:0]      count;
   logic             overflow;
   logic             underflow;
   logic [AW-1:0]    mem_addr;
   logic             mem_we;
   logic [WIDTH-1:0] mem_wd;
   logic             mem_re;
   logic [WIDTH-1:0] mem_rd;
`ifdef STACK_SPILL_HWM_EN
   logic [AW:0]      hwm;
`endif

   modport master (
      output bot_push, bot_wd, bot_pop,
      input  bot_rd, ready, count, overflow, underflow,
      input  mem_addr, mem_we, mem_wd, mem_re, mem_rd
`ifdef STACK_SPILL_HWM_EN
      , input hwm
`endif
   );

   modport slave (
      input  bot_push, bot_wd, bot_pop,
      output bot_rd, ready, count, overflow, underflow,
      output mem_addr, mem_we, mem_wd, mem_re, mem_rd
`ifdef STACK_SPILL_HWM_EN
      , output hwm
`endif
   );
endinterface

// File: rtl/stack_spill_ram.sv
// Single-port synchronous RAM backing the spill store.
// One-cycle read latency so it maps onto a block RAM.
module spill_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 255,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic [AW-1:0]    i_addr,
   input  logic             i_we,
   input  logic [WIDTH-1:0] i_wd,
   input  logic             i_re,
   output logic [WIDTH-1:0] o_rd
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wd;
      if (i_re) r_rd <= r_mem[i_addr];
   end

   assign o_rd = r_rd;
endmodule

// File: rtl/stack_spill.sv
// Far end of the J1a stack: holding register for the newest cell, RAM for the rest.
// STACK_SPILL_HWM_EN adds a high-water mark of the stored cell count.
module stack_spill
   import stack_spill_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   stack_spill_if.slave bus
);
   localparam logic [AW:0]   ONE   = (AW+1)'(1);
   localparam logic [AW:0]   FULL  = (AW+1)'(SPILL_DEPTH);
   localparam logic [AW-1:0] A_ONE = AW'(1);
   localparam logic [AW-1:0] A_TWO = AW'(2);

   state_t           r_state;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_hold;
   logic             r_ovf;
   logic             r_unf;

   state_t           w_state_nxt;
   logic [AW:0]      w_count_nxt;
   logic [WIDTH-1:0] w_hold_nxt;
   logic             w_ovf_set;
   logic             w_unf_set;
   logic             w_we;
   logic             w_re;
   logic [AW-1:0]    w_addr;
   logic [WIDTH-1:0] w_mem_rd;
   logic             w_empty;
   logic             w_full;
   logic [AW-1:0]    w_lo;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL);
   assign w_lo    = r_count[AW-1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_hold_nxt  = r_hold;
      w_ovf_set   = 1'b0;
      w_unf_set   = 1'b0;
      w_we        = 1'b0;
      w_re        = 1'b0;
      w_addr      = '0;
      unique case (r_state)
         IDLE: begin
            unique case (1'b1)
               bus.bot_push && bus.bot_pop: begin
                  w_hold_nxt = bus.bot_wd;
                  if (w_empty) begin
                     w_count_nxt = ONE;
                     w_unf_set   = 1'b1;
                  end
               end
               bus.bot_push && !bus.bot_pop: begin
                  if (w_full) begin
                     w_ovf_set = 1'b1;
                  end else begin
                     // old newest cell moves down into RAM
                     if (!w_empty) begin
                        w_we   = 1'b1;
                        w_addr = w_lo - A_ONE;
                     end
                     w_hold_nxt  = bus.bot_wd;
                     w_count_nxt = r_count + ONE;
                  end
               end
               bus.bot_pop && !bus.bot_push: begin
                  if (w_empty) begin
                     w_unf_set = 1'b1;
                  end else if (r_count == ONE) begin
                     w_count_nxt = '0;
                  end else begin
                     w_re        = 1'b1;
                     w_addr      = w_lo - A_TWO;
                     w_count_nxt = r_count - ONE;
                     w_state_nxt = FILL;
                  end
               end
               default: ;
            endcase
         end
         FILL: begin
            w_hold_nxt  = w_mem_rd;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_count <= '0;
         r_hold  <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_hold  <= w_hold_nxt;
         r_ovf   <= r_ovf | w_ovf_set;
         r_unf   <= r_unf | w_unf_set;
      end
   end

   spill_ram #(
      .WIDTH (WIDTH),
      .DEPTH (SPILL_DEPTH-1),
      .AW    (AW)
   ) u_ram (
      .clk    (clk),
      .i_addr (w_addr),
      .i_we   (w_we),
      .i_wd   (r_hold),
      .i_re   (w_re),
      .o_rd   (w_mem_rd)
   );

`ifdef STACK_SPILL_HWM_EN
   logic [AW:0] r_hwm;

   always_ff @(posedge clk) begin
      if (reset)                    r_hwm <= '0;
      else if (w_count_nxt > r_hwm) r_hwm <= w_count_nxt;
   end

   assign bus.hwm = r_hwm;
`endif

   assign bus.bot_rd    = w_empty ? FILL_PATTERN : r_hold;
   assign bus.ready     = (r_state == IDLE);
   assign bus.count     = r_count;
   assign bus.overflow  = r_ovf;
   assign bus.underflow = r_unf;
   assign bus.mem_addr  = w_addr;
   assign bus.mem_we    = w_we;
   assign bus.mem_wd    = r_hold;
   assign bus.mem_re    = w_re;
   assign bus.mem_rd    = w_mem_rd;
endmodule
